// File: rtl/msix_irq_scheduler.sv
// MSI-X interrupt scheduler: per-vector request counters, round-robin arbitration among
// pending unmasked vectors, req/ack + done/fail handshake with the issuer, and retry with backoff.
module msix_irq_scheduler #(
    parameter int unsigned C_NUM_IRQ_INPUTS = 4,
    parameter int unsigned C_VEC_WIDTH      = 5,
    parameter int unsigned C_CNT_WIDTH      = 4,
    parameter int unsigned C_MAX_RETRY      = 3,
    parameter int unsigned C_RETRY_GAP      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_NUM_IRQ_INPUTS-1:0] irq,
    input  logic [C_NUM_IRQ_INPUTS-1:0] vec_mask,
    input  logic [1:0]                  cfg_interrupt_msix_enable,
    input  logic [1:0]                  cfg_interrupt_msix_mask,
    output logic                        sched_req,
    output logic [C_VEC_WIDTH-1:0]      sched_vector,
    input  logic                        sched_ack,
    input  logic                        sched_done,
    input  logic                        sched_fail,
    output logic [C_NUM_IRQ_INPUTS-1:0] pba_pending,
    output logic                        overflow,
    output logic                        drop_err,
    output logic                        busy
);

    localparam int unsigned N  = C_NUM_IRQ_INPUTS;
    localparam int unsigned RW = (C_MAX_RETRY > 0) ? $clog2(C_MAX_RETRY + 1) : 1;
    localparam int unsigned GW = $clog2(C_RETRY_GAP + 1);
    localparam logic [C_CNT_WIDTH-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StBackoff} state_e;

    state_e                 state_q, state_d;
    logic [C_CNT_WIDTH-1:0] cnt_q [N];
    logic [C_CNT_WIDTH-1:0] cnt_d [N];
    logic [C_VEC_WIDTH-1:0] grant_q, grant_d;
    logic [C_VEC_WIDTH-1:0] rr_q, rr_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [N-1:0]           pba_q, pba_d;
    logic                   ov_q, ov_d;
    logic                   drop_q, drop_d;

    logic [N-1:0]           eligible;
    logic [N-1:0]           grant_oh;
    logic [N-1:0]           dec;
    logic                   dec_grant;
    logic                   enabled;
    logic                   grant_elig;
    logic                   hi_found;
    logic [C_VEC_WIDTH-1:0] hi_idx;
    logic [C_VEC_WIDTH-1:0] any_idx;
    logic [C_VEC_WIDTH-1:0] grant_sel;

    // Only PF0 is served; the PF1 configuration bits are intentionally ignored.
    logic unused_cfg;
    assign unused_cfg = cfg_interrupt_msix_enable[1] ^ cfg_interrupt_msix_mask[1];

    assign enabled = cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0];

    // Eligibility, one-hot of the current grant and its decrement strobe.
    always_comb begin
        eligible = '0;
        grant_oh = '0;
        dec      = '0;
        for (int i = 0; i < int'(N); i++) begin
            eligible[i] = (cnt_q[i] != '0) && !vec_mask[i];
            grant_oh[i] = (grant_q == C_VEC_WIDTH'(i));
            dec[i]      = dec_grant && grant_oh[i];
        end
        grant_elig = |(eligible & grant_oh);
    end

    // Round-robin search: lowest eligible index above the pointer, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        any_idx  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_idx = C_VEC_WIDTH'(i);
                if (i > int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = C_VEC_WIDTH'(i);
                end
            end
        end
        grant_sel = hi_found ? hi_idx : any_idx;
    end

    // Scheduler FSM next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        dec_grant = 1'b0;
        drop_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enabled && (|eligible)) begin
                    grant_d = grant_sel;
                    rr_d    = grant_sel;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (sched_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // done wins over a simultaneous fail
                if (sched_done) begin
                    dec_grant = 1'b1;
                    retry_d   = '0;
                    state_d   = StIdle;
                end else if (sched_fail) begin
                    if (32'(retry_q) < C_MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = '0;
                        state_d = StBackoff;
                    end else begin
                        dec_grant = 1'b1;
                        drop_d    = 1'b1;
                        retry_d   = '0;
                        state_d   = StIdle;
                    end
                end
            end
            StBackoff: begin
                // Retry keeps the same vector; park here while it is masked or disabled.
                if (gap_q != GW'(C_RETRY_GAP - 1)) begin
                    gap_d = gap_q + 1'b1;
                end else if (enabled && grant_elig) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating per-vector counters; simultaneous irq and dec cancel out.
    always_comb begin
        ov_d = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = cnt_q[i];
            if (irq[i] && !dec[i]) begin
                if (cnt_q[i] == CntMax) begin
                    ov_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!irq[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            pba_d[i] = (cnt_d[i] != '0);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= C_VEC_WIDTH'(N - 1);
            retry_q <= '0;
            gap_q   <= '0;
            pba_q   <= '0;
            ov_q    <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            retry_q <= retry_d;
            gap_q   <= gap_d;
            pba_q   <= pba_d;
            ov_q    <= ov_d;
            drop_q  <= drop_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sched_req    = (state_q == StReq);
    assign sched_vector = grant_q;
    assign busy         = (state_q != StIdle);
    assign pba_pending  = pba_q;
    assign overflow     = ov_q;
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_msix_irq_scheduler.sv
// Self-checking bench for msix_irq_scheduler: a per-cycle vector table plus directed sequences
// for retry/drop, counter saturation and reset mid-operation.
module tb_msix_irq_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic [3:0] vec_mask;
    logic [1:0] cfg_interrupt_msix_enable;
    logic [1:0] cfg_interrupt_msix_mask;
    logic       sched_req;
    logic [4:0] sched_vector;
    logic       sched_ack;
    logic       sched_done;
    logic       sched_fail;
    logic [3:0] pba_pending;
    logic       overflow;
    logic       drop_err;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    msix_irq_scheduler dut (
        .clk                       (clk),
        .rst                       (rst),
        .irq                       (irq),
        .vec_mask                  (vec_mask),
        .cfg_interrupt_msix_enable (cfg_interrupt_msix_enable),
        .cfg_interrupt_msix_mask   (cfg_interrupt_msix_mask),
        .sched_req                 (sched_req),
        .sched_vector              (sched_vector),
        .sched_ack                 (sched_ack),
        .sched_done                (sched_done),
        .sched_fail                (sched_fail),
        .pba_pending               (pba_pending),
        .overflow                  (overflow),
        .drop_err                  (drop_err),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] irq;
        logic [3:0] mask;
        logic [1:0] en;
        logic [1:0] fm;
        logic       ack;
        logic       done;
        logic       fail;
        logic       exp_req;
        logic       chk_vec;
        logic [4:0] exp_vec;
        logic [3:0] exp_pba;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic [3:0] irq_v, input logic [3:0] mask_v,
                                 input logic [1:0] en_v, input logic [1:0] fm_v,
                                 input logic a, input logic d, input logic f,
                                 input logic req, input int vec, input logic [3:0] pba,
                                 input logic bz);
        vec_t v;
        v.rst      = 1'b0;
        v.irq      = irq_v;
        v.mask     = mask_v;
        v.en       = en_v;
        v.fm       = fm_v;
        v.ack      = a;
        v.done     = d;
        v.fail     = f;
        v.exp_req  = req;
        v.chk_vec  = req;
        v.exp_vec  = 5'(vec);
        v.exp_pba  = pba;
        v.exp_busy = bz;
        return v;
    endfunction

    // Plain row: enabled, unmasked, only irq and handshake inputs vary.
    function automatic vec_t r(input logic [3:0] irq_v, input logic a, input logic d,
                               input logic f, input logic req, input int vec,
                               input logic [3:0] pba, input logic bz);
        return row(irq_v, 4'b0000, 2'b01, 2'b00, a, d, f, req, vec, pba, bz);
    endfunction

    function automatic vec_t rst_row();
        vec_t v;
        v          = r(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0);
        v.rst      = 1'b1;
        v.chk_vec  = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq        = '0;
        vec_mask   = '0;
        cfg_interrupt_msix_enable = 2'b01;
        cfg_interrupt_msix_mask   = 2'b00;
        sched_ack  = 1'b0;
        sched_done = 1'b0;
        sched_fail = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, output int n);
        n = 0;
        while (!sched_req && n < 100) begin
            step();
            n++;
        end
        check({name, " req seen"}, 32'(sched_req), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int ovcnt;

        // Single vector, ignored handshakes outside their states.
        tbl.push_back(rst_row());
        tbl.push_back(r(4'b0100, 0, 0, 0, 0, 0, 4'b0100, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 2, 4'b0100, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 1, 2, 4'b0100, 1));
        tbl.push_back(r(4'b0000, 0, 0, 1, 1, 2, 4'b0100, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b0100, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(r(4'b0000, 0, 1, 1, 0, 0, 4'b0000, 0));
        // Round-robin 0,1,2,3 from reset, then 1,3.
        tbl.push_back(rst_row());
        tbl.push_back(r(4'b1111, 0, 0, 0, 0, 0, 4'b1111, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 0, 4'b1111, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b1110, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 1, 4'b1110, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1110, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b1100, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 2, 4'b1100, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1100, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b1000, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 3, 4'b1000, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1000, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(r(4'b1010, 0, 0, 0, 0, 0, 4'b1010, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 1, 4'b1010, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1010, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b1000, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 3, 4'b1000, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b1000, 1));
        tbl.push_back(r(4'b0000, 0, 1, 1, 0, 0, 4'b0000, 0));
        // Masked vector keeps counting, then drains three times once unmasked.
        tbl.push_back(rst_row());
        tbl.push_back(row(4'b0010, 4'b0010, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(row(4'b0010, 4'b0010, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(row(4'b0010, 4'b0010, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(row(4'b0000, 4'b0010, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 1, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 1, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 1, 1, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 1, 0, 0, 0, 0, 4'b0010, 1));
        tbl.push_back(r(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(r(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0));
        // Function enable/mask gating (bit0 only); a raised request is never withdrawn.
        tbl.push_back(rst_row());
        tbl.push_back(row(4'b0001, 4'b0000, 2'b01, 2'b01, 0, 0, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b01, 2'b01, 0, 0, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b10, 2'b00, 0, 0, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b01, 2'b10, 0, 0, 0, 1, 0, 4'b0001, 1));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 1, 0, 4'b0001, 1));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b00, 2'b00, 1, 0, 0, 0, 0, 4'b0001, 1));
        tbl.push_back(row(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 4'b0000, 0));

        clear_inputs();
        rst = 1'b1;
        foreach (tbl[k]) begin
            rst        = tbl[k].rst;
            irq        = tbl[k].irq;
            vec_mask   = tbl[k].mask;
            cfg_interrupt_msix_enable = tbl[k].en;
            cfg_interrupt_msix_mask   = tbl[k].fm;
            sched_ack  = tbl[k].ack;
            sched_done = tbl[k].done;
            sched_fail = tbl[k].fail;
            step();
            check($sformatf("row%0d sched_req", k), 32'(sched_req), 32'(tbl[k].exp_req));
            if (tbl[k].chk_vec) begin
                check($sformatf("row%0d sched_vector", k), 32'(sched_vector),
                      32'(tbl[k].exp_vec));
            end
            check($sformatf("row%0d pba_pending", k), 32'(pba_pending), 32'(tbl[k].exp_pba));
            check($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].exp_busy));
            check($sformatf("row%0d overflow", k), 32'(overflow), 0);
            check($sformatf("row%0d drop_err", k), 32'(drop_err), 0);
        end

        // Fail every attempt: 4 requests for vector 0 separated by backoff, then a drop.
        do_reset();
        irq = 4'b0001;
        step();
        irq = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_req($sformatf("t4 try%0d", k), n);
            if (k > 0) begin
                check($sformatf("t4 try%0d gap>=16 (n=%0d)", k, n), 32'(n >= 16), 1);
            end
            check($sformatf("t4 try%0d vector", k), 32'(sched_vector), 0);
            sched_ack = 1'b1;
            step();
            sched_ack = 1'b0;
            check($sformatf("t4 try%0d req after ack", k), 32'(sched_req), 0);
            sched_fail = 1'b1;
            step();
            sched_fail = 1'b0;
            check($sformatf("t4 try%0d drop_err", k), 32'(drop_err), 32'(k == 3));
            check($sformatf("t4 try%0d busy", k), 32'(busy), 32'(k != 3));
        end
        check("t4 pba after drop", 32'(pba_pending), 0);
        step();
        check("t4 drop_err pulse width", 32'(drop_err), 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (sched_req) cnt++;
        end
        check("t4 no request after drop", 32'(cnt), 0);

        // Saturation: irq[0] held 20 cycles with no ack -> 5 overflow pulses, 15 sends.
        do_reset();
        irq   = 4'b0001;
        ovcnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (overflow) ovcnt++;
        end
        check("t5 req held without ack", 32'(sched_req), 1);
        check("t5 pba", 32'(pba_pending), 32'h1);
        irq = 4'b0000;
        step();
        check("t5 overflow ends", 32'(overflow), 0);
        check("t5 overflow pulse count", 32'(ovcnt), 5);
        cnt = 0;
        for (int it = 0; it < 40; it++) begin
            if (pba_pending[0] == 1'b0) break;
            wait_req($sformatf("t5 send%0d", it), n);
            sched_ack = 1'b1;
            step();
            sched_ack  = 1'b0;
            sched_done = 1'b1;
            step();
            sched_done = 1'b0;
            cnt++;
        end
        check("t5 sends until drained", 32'(cnt), 15);

        // Reset during WAIT.
        do_reset();
        irq = 4'b0100;
        step();
        irq = 4'b0000;
        step();
        sched_ack = 1'b1;
        step();
        sched_ack = 1'b0;
        check("t6 in wait busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 wait rst sched_req", 32'(sched_req), 0);
        check("t6 wait rst pba", 32'(pba_pending), 0);
        check("t6 wait rst busy", 32'(busy), 0);
        check("t6 wait rst vector", 32'(sched_vector), 0);

        // Reset during BACKOFF.
        irq = 4'b1000;
        step();
        irq = 4'b0000;
        step();
        check("t6 backoff pre req", 32'(sched_req), 1);
        sched_ack = 1'b1;
        step();
        sched_ack  = 1'b0;
        sched_fail = 1'b1;
        step();
        sched_fail = 1'b0;
        step();
        check("t6 in backoff busy", 32'(busy), 1);
        check("t6 in backoff req", 32'(sched_req), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 backoff rst sched_req", 32'(sched_req), 0);
        check("t6 backoff rst pba", 32'(pba_pending), 0);
        check("t6 backoff rst busy", 32'(busy), 0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (sched_req || busy) cnt++;
        end
        check("t6 no retry after rst", 32'(cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
